// File: rtl/ip_line_buffer_pingpong_pkg.sv
// Shared video constants for the ping-pong line buffer: default geometry
// and the bank-index type.
package ip_line_buffer_pingpong_pkg;

    localparam int LB_DATA_WIDTH = 8;
    localparam int LB_ADDR_WIDTH = 10;

    // One bit selects between the two banks.
    typedef logic bank_idx_t;

endpackage

// File: rtl/ip_line_buffer_bank.sv
// Single-port, read-first synchronous RAM. One bank of the line buffer.
// The array is never reset; rdata only changes on a read.
module ip_line_buffer_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port; a write on the same edge as a read does not affect that read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[address] <= wdata;
        end
    end

    // Read-first output register: captures the contents from before this edge.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[address];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ip_line_buffer_pingpong.sv
// Double-banked line buffer. The writer fills bank wr_bank while scan-out
// reads the other bank. swap exchanges them at the line boundary. In
// clear-on-read mode every read writes CLEAR_VALUE back behind itself, so
// the bank comes back to the writer already blank.
module ip_line_buffer_pingpong
    import ip_line_buffer_pingpong_pkg::*;
#(
    parameter int                    DATA_WIDTH    = LB_DATA_WIDTH,
    parameter int                    ADDR_WIDTH    = LB_ADDR_WIDTH,
    parameter int                    CLEAR_ON_READ = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  swap,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  wr_bank
);

    localparam bit CLEAR_EN = (CLEAR_ON_READ != 0);

    bank_idx_t wr_bank_q;
    bank_idx_t rd_bank_q;   // bank whose output register holds the last read
    logic      rd_valid_q;
    logic      rd_seen_q;   // a read has completed since reset

    logic [1:0][DATA_WIDTH-1:0] bank_rdata;

    // Bank select: toggles on every swap edge, back-to-back pulses included.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_q <= 1'b0;
        end else if (swap) begin
            wr_bank_q <= ~wr_bank_q;
        end
    end

    // Read bookkeeping: valid strobe and which bank's output to present.
    // rd_bank_q only moves on a read, so rd_data holds between reads even
    // after the read bank has been swapped over to the writer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_seen_q <= 1'b1;
                rd_bank_q <= ~wr_bank_q;
            end
        end
    end

    // Per-bank port mux: the write bank only ever sees the writer, the read
    // bank only sees the reader (plus its clear write-back), so the two
    // sides can never collide.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        localparam bank_idx_t IDX = (g == 1);

        logic                  is_wr;
        logic [ADDR_WIDTH-1:0] b_addr;
        logic                  b_we;
        logic [DATA_WIDTH-1:0] b_wdata;
        logic                  b_re;

        assign is_wr   = (wr_bank_q == IDX);
        assign b_addr  = is_wr ? wr_address : rd_address;
        assign b_we    = is_wr ? wr_en : (rd_en & CLEAR_EN);
        assign b_wdata = is_wr ? wr_data : CLEAR_VALUE;
        assign b_re    = ~is_wr & rd_en;

        ip_line_buffer_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .address (b_addr),
            .we      (b_we),
            .wdata   (b_wdata),
            .re      (b_re),
            .rdata   (bank_rdata[g])
        );
    end

    // The RAM output registers carry no reset, so rd_data is forced to zero
    // until the first read after reset completes.
    assign rd_data  = rd_seen_q ? bank_rdata[rd_bank_q] : '0;
    assign rd_valid = rd_valid_q;
    assign wr_bank  = wr_bank_q;

endmodule

// File: tb/tb_ip_line_buffer_pingpong.sv
// Directed bench for the ping-pong line buffer: a clear-on-read instance
// with default geometry and a non-clearing 16x512 instance.
module tb_ip_line_buffer_pingpong;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Instance A: DATA_WIDTH 8, ADDR_WIDTH 10, clear-on-read.
    logic       a_swap = 0, a_wr_en = 0, a_rd_en = 0;
    logic [9:0] a_wr_addr = '0, a_rd_addr = '0;
    logic [7:0] a_wr_data = '0;
    logic [7:0] a_rd_data;
    logic       a_rd_valid, a_wr_bank;

    ip_line_buffer_pingpong #(
        .DATA_WIDTH(8), .ADDR_WIDTH(10), .CLEAR_ON_READ(1), .CLEAR_VALUE(8'h00)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .swap(a_swap),
        .wr_en(a_wr_en), .wr_address(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_address(a_rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .wr_bank(a_wr_bank)
    );

    // Instance B: DATA_WIDTH 16, ADDR_WIDTH 9, contents preserved on read.
    logic        b_swap = 0, b_wr_en = 0, b_rd_en = 0;
    logic [8:0]  b_wr_addr = '0, b_rd_addr = '0;
    logic [15:0] b_wr_data = '0;
    logic [15:0] b_rd_data;
    logic        b_rd_valid, b_wr_bank;

    ip_line_buffer_pingpong #(
        .DATA_WIDTH(16), .ADDR_WIDTH(9), .CLEAR_ON_READ(0), .CLEAR_VALUE(16'h0000)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .swap(b_swap),
        .wr_en(b_wr_en), .wr_address(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_address(b_rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .wr_bank(b_wr_bank)
    );

    // Inputs change on the falling edge; one rising edge, then back to the
    // falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset then idle.
        reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step(); step();
        chk("rst_rd_data", 32'(a_rd_data), 32'h0);
        chk("rst_rd_valid", 32'(a_rd_valid), 32'h0);
        chk("rst_wr_bank", 32'(a_wr_bank), 32'h0);
        chk("rst_b_wr_bank", 32'(b_wr_bank), 32'h0);

        // Fill line 0..3 in bank 0, swap, read it back from bank 0.
        for (int i = 0; i < 4; i++) begin
            a_wr_en = 1; a_wr_addr = 10'(i); a_wr_data = 8'(8'h11 + i);
            step();
        end
        a_wr_en = 0;
        chk("pre_swap_valid", 32'(a_rd_valid), 32'h0);
        a_swap = 1; step(); a_swap = 0;
        chk("swap1_wr_bank", 32'(a_wr_bank), 32'h1);
        for (int i = 0; i < 4; i++) begin
            a_rd_en = 1; a_rd_addr = 10'(i);
            step();
            chk($sformatf("rd%0d_data", i), 32'(a_rd_data), 32'(8'h11 + i));
            chk($sformatf("rd%0d_valid", i), 32'(a_rd_valid), 32'h1);
        end
        a_rd_en = 0;
        step();
        chk("idle_valid", 32'(a_rd_valid), 32'h0);
        chk("idle_hold", 32'(a_rd_data), 32'h14);

        // Re-read address 2: already cleared behind the first read.
        a_rd_en = 1; a_rd_addr = 10'd2; step(); a_rd_en = 0;
        chk("reread2_data", 32'(a_rd_data), 32'h00);
        chk("reread2_valid", 32'(a_rd_valid), 32'h1);

        // Back-to-back swaps toggle each cycle and return to the same read bank.
        a_swap = 1; step();
        chk("b2b_swap_a", 32'(a_wr_bank), 32'h0);
        step(); a_swap = 0;
        chk("b2b_swap_b", 32'(a_wr_bank), 32'h1);
        for (int i = 0; i < 4; i++) begin
            a_rd_en = 1; a_rd_addr = 10'(i);
            step();
            chk($sformatf("clr%0d_data", i), 32'(a_rd_data), 32'h00);
        end
        a_rd_en = 0;

        // Same-cycle swap/write/read. Seed bank 1 address 5 with 0x3C first.
        a_wr_en = 1; a_wr_addr = 10'd5; a_wr_data = 8'h3C; step(); a_wr_en = 0;
        a_swap = 1; step(); a_swap = 0;
        chk("seed_swap_wr_bank", 32'(a_wr_bank), 32'h0);
        a_swap = 1;
        a_wr_en = 1; a_wr_addr = 10'd5; a_wr_data = 8'hA5;
        a_rd_en = 1; a_rd_addr = 10'd5;
        step();
        a_swap = 0; a_wr_en = 0; a_rd_en = 0;
        chk("same_cyc_rd_data", 32'(a_rd_data), 32'h3C);
        chk("same_cyc_wr_bank", 32'(a_wr_bank), 32'h1);
        a_rd_en = 1; a_rd_addr = 10'd5; step(); a_rd_en = 0;
        chk("same_cyc_write_lands", 32'(a_rd_data), 32'hA5);

        // Non-clearing instance, top address, repeated reads.
        b_wr_en = 1; b_wr_addr = 9'd511; b_wr_data = 16'hBEEF; step(); b_wr_en = 0;
        b_swap = 1; step(); b_swap = 0;
        chk("b_wr_bank", 32'(b_wr_bank), 32'h1);
        for (int i = 0; i < 3; i++) begin
            b_rd_en = 1; b_rd_addr = 9'd511;
            step();
            chk($sformatf("b_rd%0d_data", i), 32'(b_rd_data), 32'hBEEF);
            chk($sformatf("b_rd%0d_valid", i), 32'(b_rd_valid), 32'h1);
        end
        b_rd_en = 0;

        // Reset with a read in flight. Put 0x77 at address 7 of bank 0 and
        // make bank 0 the read bank (wr_bank=1).
        a_swap = 1; step(); a_swap = 0;
        a_wr_en = 1; a_wr_addr = 10'd7; a_wr_data = 8'h77; step(); a_wr_en = 0;
        a_swap = 1; step(); a_swap = 0;
        chk("pre_rst_wr_bank", 32'(a_wr_bank), 32'h1);
        a_rd_en = 1; a_rd_addr = 10'd7; step();
        chk("pre_rst_rd_data", 32'(a_rd_data), 32'h77);
        chk("pre_rst_rd_valid", 32'(a_rd_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_rd_valid", 32'(a_rd_valid), 32'h0);
        chk("mid_rst_rd_data", 32'(a_rd_data), 32'h0);
        chk("mid_rst_wr_bank", 32'(a_wr_bank), 32'h0);
        @(negedge clk);
        a_rd_en = 0;
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_valid_0", 32'(a_rd_valid), 32'h0);
        step();
        chk("post_rst_valid_1", 32'(a_rd_valid), 32'h0);
        chk("post_rst_rd_data", 32'(a_rd_data), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
